// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the seven-segment display path: the 16 hex glyphs
// (active-low, bit order {g,f,e,d,c,b,a}, so bit 0 is segment a and bit 6 is
// segment g), the blank pattern, the capture FSM encoding and a helper that
// maps a single active-low anode enable to its digit index.
// ---------------------------------------------------------------------------
package sseg_pkg;

   localparam int SEG_W = 7;
   localparam int NUM_DIGITS = 4;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Index = nibble value. Shared with sseg_display so encode/decode agree.
   localparam logic [SEG_W-1:0] GLYPH [16] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_CAPTURED,
      ST_MULTI
   } state_e;

   // Only meaningful when exactly one anode is low.
   function automatic logic [1:0] digit_index(input logic [NUM_DIGITS-1:0] an);
      case (an)
         4'b1110: digit_index = 2'd0;
         4'b1101: digit_index = 2'd1;
         4'b1011: digit_index = 2'd2;
         4'b0111: digit_index = 2'd3;
         default: digit_index = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sseg_decode.sv
// ---------------------------------------------------------------------------
// sseg_decode
// Combinational inverse of sseg_display: active-low segment pattern back to
// a hex nibble. Patterns that are not one of the 16 glyphs give nibble 0 and
// ok = 0.
//   pattern : in  7  segment pattern, active-low, {g,f,e,d,c,b,a}
//   nibble  : out 4  decoded hex value
//   ok      : out 1  pattern is a recognised glyph
// ---------------------------------------------------------------------------
module sseg_decode
   import sseg_pkg::*;
(
   input  logic [SEG_W-1:0] pattern,
   output logic [3:0]       nibble,
   output logic             ok
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block leaves it unassigned and a latch is never inferred.
   always_comb begin
      nibble = 4'h0;
      ok     = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (pattern == GLYPH[i]) begin
            nibble = 4'(i);
            ok     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sseg_capture.sv
// ---------------------------------------------------------------------------
// sseg_capture
// Receive side of the multiplexed 4-digit seven-segment bus. Samples the
// anode/segment lines, waits for each digit's drive to settle, captures the
// raw pattern per digit and decodes it back to hex.
//   clk        : in  1   system clock
//   rst        : in  1   asynchronous, active-high reset
//   an         : in  4   anode enables, active-low (an[i]=0 selects digit i)
//   seg        : in  7   segment lines, active-low, {g,f,e,d,c,b,a}
//   dig0..dig3 : out 7   last captured raw pattern per digit
//   hex        : out 16  decoded nibbles, hex[4i+3:4i] is digit i
//   hex_ok     : out 4   digit i holds a recognised glyph
//   frame_done : out 1   pulse once all four digits captured since last pulse
//   stale      : out 4   digit i not captured for TIMEOUT_CYCLES
//   err        : out 1   pulse on entry into a multiple-anode condition
// ---------------------------------------------------------------------------
module sseg_capture
   import sseg_pkg::*;
#(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [6:0]  dig0,
   output logic [6:0]  dig1,
   output logic [6:0]  dig2,
   output logic [6:0]  dig3,
   output logic [15:0] hex,
   output logic [3:0]  hex_ok,
   output logic        frame_done,
   output logic [3:0]  stale,
   output logic        err
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(TIMEOUT_CYCLES);

   logic [3:0]       an_m, an_s;
   logic [6:0]       seg_m, seg_s;
   logic             bus_chg;      // {an_s,seg_s} differs from last cycle
   logic             an_chg;       // an_s differs from last cycle
   logic [CW-1:0]    cnt;
   state_e           state, state_nx;
   logic [2:0]       low_cnt;
   logic             sel, multi, none;
   logic [1:0]       idx;
   logic             cap;
   logic [3:0]       cap_mask;
   logic [3:0]       seen;
   logic [3:0]       dec_nib;
   logic             dec_ok;
   logic [6:0]       dig_r     [NUM_DIGITS];
   logic [SW-1:0]    stale_cnt [NUM_DIGITS];

   // Two-flop synchronizers; reset to the idle bus (all anodes off, blank).
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values and the synchronizer really is two stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_m  <= 4'hF;
         an_s  <= 4'hF;
         seg_m <= SEG_BLANK;
         seg_s <= SEG_BLANK;
      end else begin
         an_m  <= an;
         an_s  <= an_m;
         seg_m <= seg;
         seg_s <= seg_m;
      end
   end

   // The change flags and the stability counter look one stage ahead (the
   // _m flops) so that in the first cycle a new value shows on _s the counter
   // already reads 0 and the change flags are already set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_chg <= 1'b0;
         an_chg  <= 1'b0;
         cnt     <= '0;
      end else begin
         bus_chg <= {an_m, seg_m} != {an_s, seg_s};
         an_chg  <= an_m != an_s;
         if ({an_m, seg_m} != {an_s, seg_s})
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   assign low_cnt = 3'($countones(~an_s));
   assign sel     = (low_cnt == 3'd1);
   assign multi   = (low_cnt >= 3'd2);
   assign none    = (low_cnt == 3'd0);
   assign idx     = digit_index(an_s);

   always_comb begin
      state_nx = state;
      if (multi)
         state_nx = ST_MULTI;
      else if (none)
         state_nx = ST_IDLE;
      else begin
         case (state)
            ST_IDLE, ST_MULTI:
               state_nx = ST_TRACK;
            ST_TRACK:
               // A different digit restarts tracking via IDLE; a segment-only
               // change just clears the counter and keeps tracking.
               if (an_chg)
                  state_nx = ST_IDLE;
               else if (!bus_chg && cnt == CNT_MAX)
                  state_nx = ST_CAPTURED;
            ST_CAPTURED:
               if (bus_chg)
                  state_nx = ST_TRACK;
            default:
               state_nx = ST_IDLE;
         endcase
      end
   end

   assign cap      = (state == ST_TRACK) && (state_nx == ST_CAPTURED) && sel;
   assign cap_mask = cap ? (4'b0001 << idx) : 4'b0000;

   sseg_decode u_decode (
      .pattern (seg_s),
      .nibble  (dec_nib),
      .ok      (dec_ok)
   );

   // NOTE: the per-digit arrays are only four entries of flops, not a RAM,
   // so they take the reset values directly in the reset branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         err        <= 1'b0;
         frame_done <= 1'b0;
         seen       <= 4'h0;
         hex        <= 16'h0;
         hex_ok     <= 4'h0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_r[i]     <= SEG_BLANK;
            stale_cnt[i] <= STALE_MAX;
         end
      end else begin
         state <= state_nx;
         err   <= multi && (state != ST_MULTI);

         // A capture landing on the clearing cycle seeds the next frame.
         frame_done <= (seen == 4'hF);
         if (seen == 4'hF)
            seen <= cap_mask;
         else
            seen <= seen | cap_mask;

         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_mask[i])
               stale_cnt[i] <= '0;
            else if (stale_cnt[i] != STALE_MAX)
               stale_cnt[i] <= stale_cnt[i] + 1'b1;
         end

         if (cap) begin
            dig_r[idx]              <= seg_s;
            hex[{idx, 2'b00} +: 4]  <= dec_nib;
            hex_ok[idx]             <= dec_ok;
         end
      end
   end

   always_comb begin
      stale = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++)
         stale[i] = (stale_cnt[i] == STALE_MAX);
   end

   assign dig0 = dig_r[0];
   assign dig1 = dig_r[1];
   assign dig2 = dig_r[2];
   assign dig3 = dig_r[3];

endmodule

// File: tb/tb_sseg_capture.sv
// ---------------------------------------------------------------------------
// tb_sseg_capture
// Scoreboard bench for sseg_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Stimulus pushes time-stamped expectations into a queue; a monitor on the
// falling edge pops and compares them when their cycle arrives, and keeps
// running counts of frame_done and err pulses.
// ---------------------------------------------------------------------------
module tb_sseg_capture;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 64;
   localparam int LAT     = 2 + STABLE;

   // Hand-written glyphs, active-low {g..a}.
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] GF = 7'b0001110;
   localparam logic [6:0] BAD = 7'b1010101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an  = 4'hF;
   logic [6:0]  seg = 7'h7F;
   logic [6:0]  dig0, dig1, dig2, dig3;
   logic [15:0] hex;
   logic [3:0]  hex_ok;
   logic        frame_done;
   logic [3:0]  stale;
   logic        err;

   sseg_capture #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .an         (an),
      .seg        (seg),
      .dig0       (dig0),
      .dig1       (dig1),
      .dig2       (dig2),
      .dig3       (dig3),
      .hex        (hex),
      .hex_ok     (hex_ok),
      .frame_done (frame_done),
      .stale      (stale),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum {
      K_DIG0, K_DIG1, K_DIG2, K_DIG3, K_HEX, K_OK, K_STALE,
      K_FD, K_ERR, K_FD_CNT, K_ERR_CNT
   } kind_e;

   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   fd_cnt   = 0;
   int   err_cnt  = 0;

   function automatic void expect_at(int c, kind_e k, logic [15:0] v, string nm);
      exp_t x;
      int   pos;
      x.cyc  = c;
      x.kind = k;
      x.val  = v;
      x.name = nm;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, x);
   endfunction

   function automatic logic [15:0] observe(kind_e k);
      case (k)
         K_DIG0:    return {9'h0, dig0};
         K_DIG1:    return {9'h0, dig1};
         K_DIG2:    return {9'h0, dig2};
         K_DIG3:    return {9'h0, dig3};
         K_HEX:     return hex;
         K_OK:      return {12'h0, hex_ok};
         K_STALE:   return {12'h0, stale};
         K_FD:      return {15'h0, frame_done};
         K_ERR:     return {15'h0, err};
         K_FD_CNT:  return 16'(fd_cnt);
         K_ERR_CNT: return 16'(err_cnt);
         default:   return 16'hDEAD;
      endcase
   endfunction

   task automatic check(string nm, logic [15:0] act, logic [15:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: count pulses first, then compare everything due this cycle.
   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
      if (err === 1'b1) err_cnt = err_cnt + 1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check(e.name, observe(e.kind), e.val);
      end
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] s, output int t0);
      @(negedge clk);
      t0  = cyc;
      an  = a;
      seg = s;
   endtask

   task automatic hold(input int n);
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic expect_reset(int c, string tag);
      expect_at(c, K_DIG0,  16'h7F,  {tag, "_dig0"});
      expect_at(c, K_DIG1,  16'h7F,  {tag, "_dig1"});
      expect_at(c, K_DIG2,  16'h7F,  {tag, "_dig2"});
      expect_at(c, K_DIG3,  16'h7F,  {tag, "_dig3"});
      expect_at(c, K_HEX,   16'h0,   {tag, "_hex"});
      expect_at(c, K_OK,    16'h0,   {tag, "_hex_ok"});
      expect_at(c, K_STALE, 16'hF,   {tag, "_stale"});
      expect_at(c, K_FD,    16'h0,   {tag, "_frame_done"});
      expect_at(c, K_ERR,   16'h0,   {tag, "_err"});
   endtask

   function automatic logic [3:0] an_of(int d);
      logic [3:0] a;
      a = 4'hF;
      a[d] = 1'b0;
      return a;
   endfunction

   int         t;
   int         cap_t [3];
   logic [6:0] pass_glyph [4];

   initial begin
      pass_glyph[0] = G1;
      pass_glyph[1] = G2;
      pass_glyph[2] = G3;
      pass_glyph[3] = GF;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      t = cyc;
      expect_reset(t + 1, "reset");

      // Short dwell on digit 0 never captures
      drive(4'b1110, G2, t);
      expect_at(t + LAT,     K_DIG0, 16'h7F, "short_dwell_dig0");
      expect_at(t + LAT + 1, K_HEX,  16'h0,  "short_dwell_hex");
      hold(3);
      drive(4'hF, 7'h7F, t);
      hold(8);

      // Six-cycle dwell captures exactly at 2+STABLE
      drive(4'b1110, G2, t);
      expect_at(t + LAT - 1, K_DIG0, 16'h7F,   "dwell_dig0_early");
      expect_at(t + LAT,     K_DIG0, {9'h0, G2}, "dwell_dig0");
      expect_at(t + LAT,     K_HEX,  16'h0002, "dwell_hex");
      expect_at(t + LAT,     K_OK,   16'h0001, "dwell_hex_ok");
      expect_at(t + LAT,     K_STALE, 16'hE,   "dwell_stale");
      hold(6);
      drive(4'hF, 7'h7F, t);
      hold(6);

      // Two anodes active: one err pulse, no capture
      drive(4'b1100, G5, t);
      expect_at(t + 2,  K_ERR_CNT, 16'd0, "multi_err_before");
      expect_at(t + 3,  K_ERR,     16'd1, "multi_err_pulse");
      expect_at(t + 4,  K_ERR,     16'd0, "multi_err_one_cycle");
      expect_at(t + 11, K_ERR_CNT, 16'd1, "multi_err_count");
      expect_at(t + 11, K_DIG1,    16'h7F, "multi_no_dig1");
      expect_at(t + 11, K_DIG0,    {9'h0, G2}, "multi_dig0_kept");
      hold(10);
      drive(4'b1101, G5, t);
      expect_at(t + LAT, K_DIG1,    {9'h0, G5}, "after_multi_dig1");
      expect_at(t + LAT, K_HEX,     16'h0052,   "after_multi_hex");
      expect_at(t + LAT, K_OK,      16'h0003,   "after_multi_hex_ok");
      expect_at(t + LAT, K_ERR_CNT, 16'd1,      "after_multi_err_count");
      hold(8);

      // Unrecognised pattern on digit 2
      drive(4'b1011, BAD, t);
      expect_at(t + LAT, K_DIG2, {9'h0, BAD}, "bad_glyph_dig2");
      expect_at(t + LAT, K_HEX,  16'h0052,    "bad_glyph_hex");
      expect_at(t + LAT, K_OK,   16'h0003,    "bad_glyph_hex_ok");
      hold(8);

      // Reset in the middle of a digit-3 dwell
      drive(4'b0111, GF, t);
      hold(4);
      @(negedge clk);
      rst = 1'b1;
      an  = 4'hF;
      seg = 7'h7F;
      expect_reset(t + 5, "mid_reset");
      expect_at(t + 5, K_FD_CNT, 16'd0, "mid_reset_fd_count");
      expect_at(t + 7, K_DIG3,   16'h7F, "mid_reset_no_capture");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      hold(4);

      // Refresh digits 0-2 only, then stop: stale ages out per digit
      for (int p = 0; p < 2; p++) begin
         for (int d = 0; d < 3; d++) begin
            drive(an_of(d), pass_glyph[d], t);
            if (p == 1) cap_t[d] = t + LAT;
            hold(8);
         end
      end
      expect_at(cap_t[2],      K_STALE,  16'h8,    "partial_stale");
      expect_at(cap_t[2],      K_HEX,    16'h0321, "partial_hex");
      expect_at(cap_t[2],      K_OK,     16'h0007, "partial_hex_ok");
      drive(4'hF, 7'h7F, t);
      expect_at(cap_t[0] + TIMEOUT - 1, K_STALE, 16'h8, "stale0_edge_before");
      expect_at(cap_t[0] + TIMEOUT,     K_STALE, 16'h9, "stale0_edge");
      expect_at(cap_t[1] + TIMEOUT,     K_STALE, 16'hB, "stale1_edge");
      expect_at(cap_t[2] + TIMEOUT - 1, K_STALE, 16'hB, "stale2_edge_before");
      expect_at(cap_t[2] + TIMEOUT,     K_STALE, 16'hF, "stale_all");
      expect_at(cap_t[2] + TIMEOUT,     K_FD_CNT, 16'd0, "partial_no_frame");
      while (cyc < cap_t[2] + TIMEOUT + 2) @(negedge clk);

      // Full refresh 1,2,3,F: one frame_done per pass
      for (int p = 0; p < 3; p++) begin
         for (int d = 0; d < 4; d++) begin
            drive(an_of(d), pass_glyph[d], t);
            if (d == 3) begin
               expect_at(t + LAT,     K_FD_CNT, 16'(p),     "frame_count_before");
               expect_at(t + LAT + 1, K_FD,     16'd1,      "frame_done_pulse");
               expect_at(t + LAT + 1, K_FD_CNT, 16'(p + 1), "frame_count_after");
               expect_at(t + LAT + 2, K_FD,     16'd0,      "frame_done_one_cycle");
               if (p == 0) begin
                  expect_at(t + LAT, K_HEX, 16'hF321, "full_hex");
                  expect_at(t + LAT, K_OK,  16'h000F, "full_hex_ok");
                  expect_at(t + LAT, K_DIG3, {9'h0, GF}, "full_dig3");
               end
               if (p == 2)
                  expect_at(t + LAT, K_STALE, 16'h0, "full_stale");
            end
            hold(8);
         end
      end
      drive(4'hF, 7'h7F, t);
      expect_at(t + 4, K_ERR_CNT, 16'd1, "final_err_count");
      expect_at(t + 4, K_FD_CNT,  16'd3, "final_frame_count");

      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL %s: never compared (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
Receive-side counterpart of the multiplexed 4-digit seven-segment driver. It samples the time-multiplexed anode/segment bus produced by sseg_mux, whether looped back on-chip or brought in on pins. It reconstructs the per-digit segment patterns and decodes them back to hex nibbles. Uses: self-checking display loopback on the board, and a bus monitor in simulation benches.

Parameters:
STABLE_CYCLES, 16, consecutive identical samples of {an,seg} required before a digit is captured (min 2)
TIMEOUT_CYCLES, 1048576, cycles without refresh after which a digit is flagged stale

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
an  in  4  anode enables, active-low; an[i]=0 selects digit i
seg  in  7  segment lines, active-low, bit order {g,f,e,d,c,b,a}
dig0  out  7  last captured raw pattern, digit 0
dig1  out  7  last captured raw pattern, digit 1
dig2  out  7  last captured raw pattern, digit 2
dig3  out  7  last captured raw pattern, digit 3
hex  out  16  decoded nibbles; hex[4i+3:4i] is digit i
hex_ok  out  4  hex_ok[i]=1 when dig i is a recognised hex glyph
frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse
stale  out  4  stale[i]=1 when digit i has not been captured for TIMEOUT_CYCLES
err  out  1  one-cycle pulse on entry into a multiple-anode-active condition

Behaviour:
- Reset values: dig0..dig3=7'h7F (blank), hex=0, hex_ok=0, frame_done=0, err=0, stale=4'hF; stale counters saturated, seen mask=0, stability counter=0, state=IDLE.
- Input sync: an and seg each pass through a 2-FF synchronizer. All logic below acts on the synchronized values an_s and seg_s.
- Stability counter:
  - Cleared whenever {an_s,seg_s} differs from the previous cycle's value.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
- sel = exactly one bit of an_s low. multi = two or more bits low. none = an_s==4'hF.
- FSM:
  - IDLE: nothing selected, or inputs changing.
  - IDLE -> TRACK on sel.
  - TRACK -> IDLE on none, or on an_s change to a different single digit (restart tracking). TRACK -> MULTI on multi.
  - TRACK -> CAPTURED when the counter reaches STABLE_CYCLES-1.
  - CAPTURED: holds while inputs stay unchanged. Any change -> IDLE/TRACK/MULTI re-evaluated the same cycle.
  - MULTI: no captures. Exit to IDLE or TRACK when multi deasserts.
- Capture occurs exactly once per stable dwell, in the cycle of the TRACK -> CAPTURED transition. That cycle:
  - dig[i] <= seg_s and hex nibble / hex_ok[i] update from the decoder.
  - stale counter i cleared and stale[i] <= 0.
  - seen[i] <= 1.
  - Latency from an input change to updated dig: 2 (sync) + STABLE_CYCLES cycles.
- A dwell shorter than STABLE_CYCLES (ghosting or switching glitch) never captures.
- frame_done:
  - Pulses in the cycle after seen becomes 4'hF, and seen clears in that same cycle.
  - If a capture coincides with the clear, seen <= that digit's bit only. No capture is lost.
- Re-capturing an already-seen digit before the frame completes updates dig and does not affect frame_done.
- err pulses for one cycle only on the IDLE/TRACK/CAPTURED -> MULTI transition, not while remaining in MULTI.
- Stale counters: one per digit, width $clog2(TIMEOUT_CYCLES+1), increment each cycle, saturate. stale[i]=1 once counter i reaches TIMEOUT_CYCLES.
- Decode, active-low {g..a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Any other pattern gives nibble 0 and hex_ok=0.
- Reset asserted mid-dwell or mid-frame returns everything to reset values immediately. No capture completes.

Decomposition:
- Package sseg_pkg: the 16 glyph constants (shared with sseg_display), segment bit-order constants, FSM state encoding.
- Sub-module sseg_decode: combinational 7-bit pattern -> {ok, nibble}, the exact inverse of sseg_display. Instantiated once, on seg_s.

Test Plan:
- Bench uses STABLE_CYCLES=4 and TIMEOUT_CYCLES=64 throughout.
- Drive a sseg_mux instance with digits 1,2,3,F through sseg_display -> hex=16'hF321, hex_ok=4'hF; frame_done pulses once per full refresh cycle.
- Hold an=4'b1110, seg=7'b0100100 for 3 cycles, then change -> no capture, dig0 stays 7'h7F. Hold it for 6 cycles -> dig0=7'b0100100, hex[3:0]=2 at cycle 2+4 after the change.
- Drive an=4'b1100 for 10 cycles -> exactly one err pulse, no dig update; then an=4'b1101 stable -> capture into digit 1.
- Drive seg=7'b1010101 on digit 2 -> dig2=7'b1010101, hex_ok[2]=0, hex[11:8]=0.
- Refresh digits 0-2 only -> stale[3] stays 1 and stale[2:0]=0; stop all refresh -> stale=4'hF 64 cycles after each digit's last capture; frame_done never pulses.
- Assert rst in the middle of a digit-3 dwell -> all outputs return to reset values; after release, the first frame_done needs all four digits captured again.
